// File: rtl/stage2_3_transfer_pkg.sv
// Shared constants and types for the stage-2 to stage-3 pipeline transfer block.
// Holds the NOP encoding, the LOAD opcode/funct3 values and the load-data FSM states.
package stage2_3_transfer_pkg;

  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [6:0]  OPC_LOAD = 7'b000_0011;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DMISS = 2'd1,
    HOLD  = 2'd2
  } state_t;

  function automatic logic is_load(input logic [31:0] inst);
    return inst[6:0] == OPC_LOAD;
  endfunction

endpackage

// File: rtl/stage2_3_transfer_if.sv
// Bundle of the stage-2 inputs, memory status and stage-3 outputs of the transfer block.
// The master side is the upstream/environment; the slave side is the pipeline register.
interface stage2_3_transfer_if #(
  parameter int CNT_W = 32
);
  logic [31:0]      s2_pc;
  logic [31:0]      s2_inst;
  logic [31:0]      s2_alu_out;
  logic             s2_jump;
  logic             ic_stall;
  logic             dc_stall;
  logic [31:0]      dc_dout;

  logic [31:0]      pc;
  logic [31:0]      inst;
  logic [31:0]      alu_out;
  logic             jump;
  logic [31:0]      dout;
  logic             valid;
  logic             stall;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] instret_cnt;

  modport master (
    output s2_pc, s2_inst, s2_alu_out, s2_jump, ic_stall, dc_stall, dc_dout,
    input  pc, inst, alu_out, jump, dout, valid, stall, cycle_cnt, instret_cnt
  );

  modport slave (
    input  s2_pc, s2_inst, s2_alu_out, s2_jump, ic_stall, dc_stall, dc_dout,
    output pc, inst, alu_out, jump, dout, valid, stall, cycle_cnt, instret_cnt
  );
endinterface

// File: rtl/stage2_3_transfer_load_aligner.sv
// Combinational load-data aligner: picks the addressed byte/halfword and extends it.
// Anything that is not a recognised load passes the raw word through.
module load_aligner
  import stage2_3_transfer_pkg::*;
(
  input  logic [31:0] word,
  input  logic        load,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr,
  output logic [31:0] dout
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // NOTE: every output of an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    byte_sel = word[{addr, 3'b000} +: 8];
    half_sel = addr[1] ? word[31:16] : word[15:0];
    dout     = word;
    if (load) begin
      case (funct3)
        F3_LB:   dout = {{24{byte_sel[7]}}, byte_sel};
        F3_LBU:  dout = {24'h0, byte_sel};
        F3_LH:   dout = {{16{half_sel[15]}}, half_sel};
        F3_LHU:  dout = {16'h0, half_sel};
        F3_LW:   dout = word;
        default: dout = word;
      endcase
    end
  end

endmodule

// File: rtl/stage2_3_transfer.sv
// Stage-2 to stage-3 pipeline register with stall, jump flush, load-data hold FSM and
// cycle / retired-instruction counters.
module stage2_3_transfer
  import stage2_3_transfer_pkg::*;
#(
  parameter logic [31:0] PC_RESET = 32'h0000_2000,
  parameter int          CNT_W    = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  stage2_3_transfer_if.slave   bus
);

  state_t           state;
  logic [31:0]      dout_hold;
  logic [31:0]      load_src;
  logic [CNT_W-1:0] cycle_q;
  logic [CNT_W-1:0] instret_q;

  assign bus.stall       = bus.ic_stall | bus.dc_stall;
  assign bus.cycle_cnt   = cycle_q;
  assign bus.instret_cnt = instret_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.pc      <= PC_RESET;
      bus.inst    <= NOP;
      bus.alu_out <= '0;
      bus.jump    <= 1'b0;
      bus.valid   <= 1'b0;
      cycle_q     <= '0;
      instret_q   <= '0;
    end else begin
      cycle_q <= cycle_q + CNT_W'(1);
      if (!bus.stall) begin
        if (bus.valid) instret_q <= instret_q + CNT_W'(1);
        bus.pc      <= bus.s2_pc;
        bus.alu_out <= bus.s2_alu_out;
        // A taken jump in stage 3 squashes the wrong-path instruction arriving behind it.
        if (bus.jump) begin
          bus.inst  <= NOP;
          bus.jump  <= 1'b0;
          bus.valid <= 1'b0;
        end else begin
          bus.inst  <= bus.s2_inst;
          bus.jump  <= bus.s2_jump;
          bus.valid <= 1'b1;
        end
      end
    end
  end

  // Returned load data is captured when an icache stall keeps stage 3 frozen past the dcache return.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RUN;
      dout_hold <= '0;
    end else begin
      case (state)
        RUN: begin
          if (bus.dc_stall) begin
            state <= DMISS;
          end else if (bus.ic_stall && is_load(bus.inst)) begin
            state     <= HOLD;
            dout_hold <= bus.dc_dout;
          end
        end
        DMISS: begin
          if (!bus.dc_stall) begin
            if (bus.ic_stall) begin
              state     <= HOLD;
              dout_hold <= bus.dc_dout;
            end else begin
              state <= RUN;
            end
          end
        end
        HOLD: begin
          if (!bus.stall) state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

  assign load_src = (state == HOLD) ? dout_hold : bus.dc_dout;

  load_aligner u_load_aligner (
    .word   (load_src),
    .load   (is_load(bus.inst)),
    .funct3 (bus.inst[14:12]),
    .addr   (bus.alu_out[1:0]),
    .dout   (bus.dout)
  );

endmodule

// File: tb/tb_stage2_3_transfer.sv
// Directed self-checking bench for stage2_3_transfer: reset, capture, load alignment,
// jump flush, dcache/icache stalls with load-data hold, and reset during a miss.
module tb_stage2_3_transfer;
  import stage2_3_transfer_pkg::*;

  localparam logic [31:0] I_LB   = 32'h0000_0083;
  localparam logic [31:0] I_LH   = 32'h0000_1083;
  localparam logic [31:0] I_LW   = 32'h0000_2083;
  localparam logic [31:0] I_LD3  = 32'h0000_3083;
  localparam logic [31:0] I_LBU  = 32'h0000_4083;
  localparam logic [31:0] I_LHU  = 32'h0000_5083;
  localparam logic [31:0] I_ADDI = 32'h00A0_0093;
  localparam logic [31:0] I_JAL  = 32'h0000_006F;

  logic clk = 1'b0;
  logic reset;

  int n_checks = 0;
  int n_fails  = 0;

  // Reference model of the valid/jump slot and the two counters.
  logic        m_valid, m_jump;
  logic [31:0] m_cycle, m_instret;
  logic [31:0] saved_instret;

  stage2_3_transfer_if #(.CNT_W(32)) bus ();

  stage2_3_transfer #(
    .PC_RESET (32'h0000_2000),
    .CNT_W    (32)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    if (reset) begin
      m_valid   = 1'b0;
      m_jump    = 1'b0;
      m_cycle   = 32'd0;
      m_instret = 32'd0;
    end else begin
      m_cycle++;
      if (!(bus.ic_stall || bus.dc_stall)) begin
        if (m_valid) m_instret++;
        if (m_jump) begin
          m_valid = 1'b0;
          m_jump  = 1'b0;
        end else begin
          m_valid = 1'b1;
          m_jump  = bus.s2_jump;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".valid"},   32'(bus.valid),  32'(m_valid));
    check({tag, ".jump"},    32'(bus.jump),   32'(m_jump));
    check({tag, ".cycle"},   bus.cycle_cnt,   m_cycle);
    check({tag, ".instret"}, bus.instret_cnt, m_instret);
  endtask

  task automatic issue(input logic [31:0] inst, input logic [31:0] pc, input logic [31:0] addr);
    bus.s2_inst    = inst;
    bus.s2_pc      = pc;
    bus.s2_alu_out = addr;
    step();
  endtask

  initial begin
    reset          = 1'b1;
    bus.s2_pc      = '0;
    bus.s2_inst    = '0;
    bus.s2_alu_out = '0;
    bus.s2_jump    = 1'b0;
    bus.ic_stall   = 1'b0;
    bus.dc_stall   = 1'b0;
    bus.dc_dout    = '0;

    // Reset state
    step();
    check("rst.pc",        bus.pc,          32'h0000_2000);
    check("rst.inst",      bus.inst,        NOP);
    check("rst.alu_out",   bus.alu_out,     32'h0);
    check("rst.valid",     32'(bus.valid),  32'd0);
    check("rst.jump",      32'(bus.jump),   32'd0);
    check("rst.cycle",     bus.cycle_cnt,   32'd0);
    check("rst.instret",   bus.instret_cnt, 32'd0);
    check("rst.state",     32'(dut.state),  32'(RUN));
    check("rst.dout_hold", dut.dout_hold,   32'h0);

    // Basic capture and first retirement
    reset = 1'b0;
    issue(I_ADDI, 32'h0000_2000, 32'h0);
    check("cap.inst",  bus.inst,          I_ADDI);
    check("cap.valid", 32'(bus.valid),    32'd1);
    check("cap.pc",    bus.pc,            32'h0000_2000);
    check("cap.cycle", bus.cycle_cnt,     32'd1);
    step();
    check("cap.instret", bus.instret_cnt, 32'd1);
    check_model("cap");

    // Load alignment
    bus.dc_dout = 32'h80FF_1234;
    issue(I_LB, 32'h0000_2004, 32'h0000_1003);
    check("lb3",  bus.dout, 32'hFFFF_FF80);
    issue(I_LBU, 32'h0000_2004, 32'h0000_1003);
    check("lbu3", bus.dout, 32'h0000_0080);
    issue(I_LHU, 32'h0000_2004, 32'h0000_1002);
    check("lhu2", bus.dout, 32'h0000_80FF);
    issue(I_LH, 32'h0000_2004, 32'h0000_1003);
    check("lh3",  bus.dout, 32'hFFFF_80FF);
    issue(I_LH, 32'h0000_2004, 32'h0000_1000);
    check("lh0",  bus.dout, 32'h0000_1234);
    issue(I_LBU, 32'h0000_2004, 32'h0000_1001);
    check("lbu1", bus.dout, 32'h0000_0012);
    issue(I_LW, 32'h0000_2004, 32'h0000_1000);
    check("lw0",  bus.dout, 32'h80FF_1234);
    issue(I_LD3, 32'h0000_2004, 32'h0000_1003);
    check("ld_undef", bus.dout, 32'h80FF_1234);
    issue(I_ADDI, 32'h0000_2004, 32'h0000_1003);
    check("nonload",  bus.dout, 32'h80FF_1234);

    // Jump flush
    bus.s2_jump = 1'b1;
    issue(I_JAL, 32'h0000_2008, 32'h0);
    check("jal.jump", 32'(bus.jump), 32'd1);
    check("jal.inst", bus.inst,      I_JAL);
    saved_instret = bus.instret_cnt;
    bus.s2_jump = 1'b0;
    issue(32'h0010_0113, 32'h0000_200C, 32'h0);
    check("flush.inst",    bus.inst,          NOP);
    check("flush.valid",   32'(bus.valid),    32'd0);
    check("flush.jump",    32'(bus.jump),     32'd0);
    check("flush.pc",      bus.pc,            32'h0000_200C);
    check("flush.instret", bus.instret_cnt,   saved_instret + 32'd1);
    issue(32'h0010_0113, 32'h0000_200C, 32'h0);
    check("post.inst",     bus.inst,          32'h0010_0113);
    check("post.instret",  bus.instret_cnt,   saved_instret + 32'd1);
    check_model("flush");

    // Dcache miss for three cycles
    issue(I_LW, 32'h0000_2010, 32'h0000_1000);
    bus.s2_inst  = 32'h0020_0193;
    bus.s2_pc    = 32'h0000_2014;
    bus.dc_stall = 1'b1;
    bus.dc_dout  = 32'h0;
    #1;
    check("dmiss.stall", 32'(bus.stall), 32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("dmiss.pc",    bus.pc,         32'h0000_2010);
      check("dmiss.inst",  bus.inst,       I_LW);
      check("dmiss.state", 32'(dut.state), 32'(DMISS));
    end
    bus.dc_stall = 1'b0;
    bus.dc_dout  = 32'h1234_5678;
    #1;
    check("dret.stall", 32'(bus.stall), 32'd0);
    check("dret.dout",  bus.dout,       32'h1234_5678);
    step();
    check("dret.inst",  bus.inst,       32'h0020_0193);
    check("dret.pc",    bus.pc,         32'h0000_2014);
    check("dret.state", 32'(dut.state), 32'(RUN));
    check_model("dmiss");

    // Load data returns under an icache stall
    issue(I_LW, 32'h0000_2018, 32'h0000_1000);
    bus.s2_inst  = 32'h0030_0213;
    bus.s2_pc    = 32'h0000_201C;
    bus.dc_stall = 1'b1;
    step();
    check("h.dmiss", 32'(dut.state), 32'(DMISS));
    bus.dc_stall = 1'b0;
    bus.ic_stall = 1'b1;
    bus.dc_dout  = 32'h1234_5678;
    #1;
    check("h.ret_dout", bus.dout, 32'h1234_5678);
    step();
    check("h.state",     32'(dut.state), 32'(HOLD));
    check("h.dout_hold", dut.dout_hold,  32'h1234_5678);
    bus.dc_dout = 32'hDEAD_BEEF;
    #1;
    check("h.dout0", bus.dout, 32'h1234_5678);
    step();
    check("h.state1", 32'(dut.state), 32'(HOLD));
    check("h.inst1",  bus.inst,       I_LW);
    check("h.dout1",  bus.dout,       32'h1234_5678);
    bus.dc_stall = 1'b1;
    step();
    check("h.state_dc", 32'(dut.state), 32'(HOLD));
    check("h.dout_dc",  bus.dout,       32'h1234_5678);
    bus.dc_stall = 1'b0;
    bus.ic_stall = 1'b0;
    #1;
    check("h.dout2", bus.dout, 32'h1234_5678);
    step();
    check("h.state_run", 32'(dut.state), 32'(RUN));
    check("h.inst_adv",  bus.inst,       32'h0030_0213);
    check("h.dout_raw",  bus.dout,       32'hDEAD_BEEF);
    check_model("hold");

    // Reset asserted during a dcache miss
    issue(I_LW, 32'h0000_2020, 32'h0000_1000);
    bus.dc_stall = 1'b1;
    step();
    check("r.dmiss",     32'(dut.state), 32'(DMISS));
    check("r.hold_prev", dut.dout_hold,  32'h1234_5678);
    reset = 1'b1;
    step();
    check("r.state",     32'(dut.state),  32'(RUN));
    check("r.inst",      bus.inst,        NOP);
    check("r.pc",        bus.pc,          32'h0000_2000);
    check("r.valid",     32'(bus.valid),  32'd0);
    check("r.cycle",     bus.cycle_cnt,   32'd0);
    check("r.instret",   bus.instret_cnt, 32'd0);
    check("r.dout_hold", dut.dout_hold,   32'h0);
    reset        = 1'b0;
    bus.dc_stall = 1'b0;
    step();
    check_model("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
